// File: rtl/serial_ripple_adder_if.sv
// Operand/result handshake bundle for serial_ripple_adder.
// The sub field exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_ripple_adder.sv
// Digit-serial ripple-carry adder: DIGIT bits per clock, result after WIDTH/DIGIT cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A + ~B + 1, cin ignored).
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | adding one digit per cycle, LSB digit first
// S_DONE | result held with out_valid=1 until out_ready
module serial_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_ripple_adder_if.slave bus
);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_ripple_adder: WIDTH must be a positive multiple of DIGIT");
  end

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, busy_q;

  logic             sub_w;
  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_c, msb_cin;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif

  // One DIGIT-wide ripple slice; the carry into its top bit feeds the overflow flag.
  assign dig_a            = op_a_q[DIGIT-1:0];
  assign dig_b            = op_b_q[DIGIT-1:0];
  assign {dig_c, dig_s}   = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
  assign msb_cin          = dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];

  if (DIGIT == WIDTH) begin : g_full_digit
    assign sum_shift = dig_s;
  end else begin : g_part_digit
    assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.a;
          op_b_d  = sub_w ? ~bus.b : bus.b;
          carry_d = sub_w | bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        op_a_d  = op_a_q >> DIGIT;
        op_b_d  = op_b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dig_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = dig_c;
          ovf_d   = msb_cin ^ dig_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed and randomised checks of serial_ripple_adder at WIDTH=8, DIGIT in {1,2,4,8}.
// The DIGIT=2 instance carries the directed scenarios; all four run the random sweep.
module tb_serial_ripple_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tb_in_valid, tb_cin, tb_sub, tb_out_ready;
  logic [7:0] tb_a, tb_b;
  int errors = 0;
  int checks = 0;

  serial_ripple_adder_if #(.WIDTH(8)) if_d1 ();
  serial_ripple_adder_if #(.WIDTH(8)) if_d2 ();
  serial_ripple_adder_if #(.WIDTH(8)) if_d4 ();
  serial_ripple_adder_if #(.WIDTH(8)) if_d8 ();

  assign if_d1.in_valid = tb_in_valid;  assign if_d2.in_valid = tb_in_valid;
  assign if_d4.in_valid = tb_in_valid;  assign if_d8.in_valid = tb_in_valid;
  assign if_d1.a = tb_a;  assign if_d2.a = tb_a;  assign if_d4.a = tb_a;  assign if_d8.a = tb_a;
  assign if_d1.b = tb_b;  assign if_d2.b = tb_b;  assign if_d4.b = tb_b;  assign if_d8.b = tb_b;
  assign if_d1.cin = tb_cin;  assign if_d2.cin = tb_cin;
  assign if_d4.cin = tb_cin;  assign if_d8.cin = tb_cin;
`ifdef SERIAL_ADDER_SUB_EN
  assign if_d1.sub = tb_sub;  assign if_d2.sub = tb_sub;
  assign if_d4.sub = tb_sub;  assign if_d8.sub = tb_sub;
`endif
  assign if_d2.out_ready = tb_out_ready;
  assign if_d1.out_ready = 1'b1;
  assign if_d4.out_ready = 1'b1;
  assign if_d8.out_ready = 1'b1;

  serial_ripple_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if_d1));
  serial_ripple_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .bus(if_d2));
  serial_ripple_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if_d4));
  serial_ripple_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(if_d8));

  logic       sw_valid [4];
  logic [7:0] sw_sum   [4];
  logic       sw_cout  [4];
  logic       sw_ovf   [4];
  assign sw_valid[0] = if_d1.out_valid; assign sw_sum[0] = if_d1.sum;
  assign sw_cout[0]  = if_d1.cout;      assign sw_ovf[0] = if_d1.ovf;
  assign sw_valid[1] = if_d2.out_valid; assign sw_sum[1] = if_d2.sum;
  assign sw_cout[1]  = if_d2.cout;      assign sw_ovf[1] = if_d2.ovf;
  assign sw_valid[2] = if_d4.out_valid; assign sw_sum[2] = if_d4.sum;
  assign sw_cout[2]  = if_d4.cout;      assign sw_ovf[2] = if_d4.ovf;
  assign sw_valid[3] = if_d8.out_valid; assign sw_sum[3] = if_d8.sum;
  assign sw_cout[3]  = if_d8.cout;      assign sw_ovf[3] = if_d8.ovf;
  int sw_lat_exp [4] = '{8, 4, 2, 1};

  // Returns {ovf, cout, sum} from plain 9-bit arithmetic.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic s);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] t;
    logic       v;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    v  = (a[7] == bb[7]) && (t[7] != a[7]);
    return {v, t[8], t[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    tb_a = a; tb_b = b; tb_cin = c; tb_sub = s;
    tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (if_d2.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic transfer();
    tb_out_ready = 1'b1;
    tick();
    tb_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (if_d2.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", if_d2.in_ready); end
    checks++; if (if_d2.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", if_d2.out_valid); end
    checks++; if (if_d2.sum !== 8'h00) begin errors++; $display("FAIL rst_sum: got %h want 00", if_d2.sum); end
    checks++; if ({if_d2.cout, if_d2.ovf, if_d2.busy} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {if_d2.cout, if_d2.ovf, if_d2.busy}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (if_d2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", if_d2.in_ready); end
  endtask

  task automatic test_add_basic();
    int lat;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    checks++; if ({if_d2.busy, if_d2.out_valid, if_d2.in_ready} !== 3'b100) begin errors++; $display("FAIL basic_run_flags: got %b want 100", {if_d2.busy, if_d2.out_valid, if_d2.in_ready}); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL basic_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=1 sum=00", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
    checks++; if ({if_d2.out_valid, if_d2.in_ready, if_d2.busy} !== 3'b010) begin errors++; $display("FAIL basic_release: got %b want 010", {if_d2.out_valid, if_d2.in_ready, if_d2.busy}); end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_valid(lat);
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b1, 1'b0, 8'h80}) begin errors++; $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want ovf=1 cout=0 sum=80", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
    start_op(8'h80, 8'h80, 1'b1, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_neg_latency: got %0d want 4", lat); end
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b1, 1'b1, 8'h01}) begin errors++; $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h want ovf=1 cout=1 sum=01", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({if_d2.out_valid, if_d2.in_ready, if_d2.sum} !== {1'b1, 1'b0, 8'h4B}) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%h want valid=1 ready=0 sum=4b", i, if_d2.out_valid, if_d2.in_ready, if_d2.sum); end
    end
    transfer();
    checks++; if ({if_d2.out_valid, if_d2.in_ready} !== 2'b01) begin errors++; $display("FAIL bp_transfer: got valid=%b ready=%b want 0 1", if_d2.out_valid, if_d2.in_ready); end
    tick();
    checks++; if (if_d2.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single: got valid=%b want 0", if_d2.out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if ({if_d2.out_valid, if_d2.busy, if_d2.in_ready} !== 3'b000) begin errors++; $display("FAIL midrst_assert: got %b want 000", {if_d2.out_valid, if_d2.busy, if_d2.in_ready}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({if_d2.out_valid, if_d2.in_ready} !== 2'b01) begin errors++; $display("FAIL midrst_release: got valid=%b ready=%b want 0 1", if_d2.out_valid, if_d2.in_ready); end
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b0, 1'b0, 8'h46}) begin errors++; $display("FAIL midrst_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=0 sum=46", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    start_op(8'h05, 8'h07, 1'b0, 1'b1);
    wait_valid(lat);
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b0, 1'b0, 8'hFE}) begin errors++; $display("FAIL sub_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=0 sum=fe", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
    start_op(8'h05, 8'h07, 1'b1, 1'b0);
    wait_valid(lat);
    checks++; if ({if_d2.ovf, if_d2.cout, if_d2.sum} !== {1'b0, 1'b0, 8'h0D}) begin errors++; $display("FAIL sub0_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=0 sum=0d", if_d2.ovf, if_d2.cout, if_d2.sum); end
    transfer();
  endtask
`endif

  task automatic test_sweep();
    logic [7:0] ra, rb;
    logic       rc, rs;
    logic [9:0] exp;
    logic       seen [4];
    tb_out_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = ref_add(ra, rb, rc, rs);
      for (int d = 0; d < 4; d++) seen[d] = 1'b0;
      start_op(ra, rb, rc, rs);
      for (int k = 1; k <= 10; k++) begin
        tick();
        for (int d = 0; d < 4; d++) begin
          if (!seen[d] && sw_valid[d] === 1'b1) begin
            seen[d] = 1'b1;
            checks++; if (k !== sw_lat_exp[d]) begin errors++; $display("FAIL sweep_latency d%0d op%0d: got %0d want %0d", d, i, k, sw_lat_exp[d]); end
            checks++; if ({sw_ovf[d], sw_cout[d], sw_sum[d]} !== exp) begin errors++; $display("FAIL sweep_result d%0d op%0d a=%h b=%h cin=%b sub=%b: got %h want %h", d, i, ra, rb, rc, rs, {sw_ovf[d], sw_cout[d], sw_sum[d]}, exp); end
          end
        end
      end
      for (int d = 0; d < 4; d++) begin
        checks++; if (!seen[d]) begin errors++; $display("FAIL sweep_timeout d%0d op%0d: got no out_valid want one", d, i); end
      end
    end
    tb_out_ready = 1'b0;
  endtask

  initial begin
    tb_in_valid = 1'b0; tb_cin = 1'b0; tb_sub = 1'b0; tb_out_ready = 1'b0;
    tb_a = 8'h00; tb_b = 8'h00;
    test_reset();
    test_add_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
